sc_mult_engine: RTL and testbench

- Parametrised stochastic-computing multiplier engine for multiple lanes.
- Converts binary operand pairs to bitstreams using two shared LFSR stochastic number generators (SNGs).
- Multiplies each stream pair in unipolar (AND) or bipolar (XNOR) mode, then counts ones over a programmable stream length `nummax`.
- Sits between the binary datapath and the SC arithmetic fabric, and returns binary products with a start/done handshake.

---
 rtl/sc_pkg.sv | 38 +++
 rtl/sc_lfsr.sv | 39 +++
 rtl/sc_mult_engine.sv | 161 ++++++++++++++++
 tb/tb_sc_mult_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types, LFSR tap table and default seeds for the stochastic multiplier engine.
package sc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sc_state_t;

   typedef enum logic {
      SC_UNIPOLAR = 1'b0,
      SC_BIPOLAR  = 1'b1
   } sc_mode_t;

   localparam logic [7:0] SC_SEED_A_DEF = 8'h01;
   localparam logic [7:0] SC_SEED_B_DEF = 8'hA5;

   // Maximal-length Fibonacci feedback masks; bit k set means stage k+1 is tapped.
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      case (width)
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci maximal-length LFSR used as a stochastic number generator; reloadable seed.
module sc_lfsr
   import sc_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             advance,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = SEED;
      end else if (advance) begin
         q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sc_mult_engine.sv
// Multi-lane stochastic-computing multiplier with start/done handshake.
// Optional raw-stream debug outputs when SC_STREAM_OUT_EN is defined.
module sc_mult_engine
   import sc_pkg::*;
#(
   parameter int unsigned      WIDTH  = 8,
   parameter int unsigned      LEN_W  = 9,
   parameter int unsigned      LANES  = 4,
   parameter logic [WIDTH-1:0] SEED_A = WIDTH'(SC_SEED_A_DEF),
   parameter logic [WIDTH-1:0] SEED_B = WIDTH'(SC_SEED_B_DEF)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   mode,
   input  logic [LEN_W-1:0]       nummax,
   input  logic [LANES*WIDTH-1:0] a_val,
   input  logic [LANES*WIDTH-1:0] b_val,
   output logic                   busy,
   output logic                   done,
   output logic [LANES*LEN_W-1:0] result
`ifdef SC_STREAM_OUT_EN
   ,
   output logic [LANES-1:0]       dbg_sa,
   output logic [LANES-1:0]       dbg_sb,
   output logic [LANES-1:0]       dbg_prod,
   output logic                   dbg_valid
`endif
);

   sc_state_t                     state_q, state_d;
   sc_mode_t                      mode_q, mode_d;
   logic [LEN_W-1:0]              nummax_q, nummax_d;
   logic [LANES*WIDTH-1:0]        a_q, a_d;
   logic [LANES*WIDTH-1:0]        b_q, b_d;
   logic [LEN_W-1:0]              cnt_q, cnt_d;
   logic [LANES-1:0][LEN_W-1:0]   lane_cnt_q, lane_cnt_d;
   logic [LANES*LEN_W-1:0]        result_q, result_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          accept;
   logic                          running;
   logic [WIDTH-1:0]              lfsr_a;
   logic [WIDTH-1:0]              lfsr_b;
   logic [LANES-1:0]              sa;
   logic [LANES-1:0]              sb;
   logic [LANES-1:0]              prod;

   assign running = (state_q == RUN);

   sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .advance (running),
      .q       (lfsr_a)
   );

   sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .advance (running),
      .q       (lfsr_b)
   );

   // Per-lane SNG comparators and product gate.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign sa[i]   = (a_q[i*WIDTH +: WIDTH] >= lfsr_a);
      assign sb[i]   = (b_q[i*WIDTH +: WIDTH] >= lfsr_b);
      assign prod[i] = (mode_q == SC_BIPOLAR) ? ~(sa[i] ^ sb[i]) : (sa[i] & sb[i]);
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      nummax_d   = nummax_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      lane_cnt_d = lane_cnt_q;
      result_d   = result_q;
      done_d     = 1'b0;
      accept     = 1'b0;

      case (state_q)
         IDLE: begin
            accept = start;
         end
         RUN: begin
            cnt_d = cnt_q + LEN_W'(1);
            for (int i = 0; i < LANES; i++) begin
               lane_cnt_d[i] = lane_cnt_q[i] + LEN_W'(prod[i]);
            end
            if ((cnt_q + LEN_W'(1)) == nummax_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d   = 1'b1;
            result_d = lane_cnt_q;
            state_d  = IDLE;
            accept   = start;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Launch: capture operands and restart the stream from a clean state.
      if (accept) begin
         mode_d     = sc_mode_t'(mode);
         nummax_d   = nummax;
         a_d        = a_val;
         b_d        = b_val;
         cnt_d      = '0;
         lane_cnt_d = '0;
         state_d    = (nummax != '0) ? RUN : DONE;
      end

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= SC_UNIPOLAR;
         nummax_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         lane_cnt_q <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         nummax_q   <= nummax_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         lane_cnt_q <= lane_cnt_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

`ifdef SC_STREAM_OUT_EN
   assign dbg_sa    = running ? sa   : '0;
   assign dbg_sb    = running ? sb   : '0;
   assign dbg_prod  = running ? prod : '0;
   assign dbg_valid = running;
`endif

endmodule

// File: tb/tb_sc_mult_engine.sv
// Self-checking bench for sc_mult_engine: vector table, randomized saturated/full-period runs, corner sequences.
module tb_sc_mult_engine;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LEN_W = 9;
   localparam int unsigned LANES = 4;
   localparam int unsigned PMAX  = (1 << WIDTH) - 1;

   logic                   clk;
   logic                   rst_n;
   logic                   start;
   logic                   mode;
   logic [LEN_W-1:0]       nummax;
   logic [LANES*WIDTH-1:0] a_val;
   logic [LANES*WIDTH-1:0] b_val;
   logic                   busy;
   logic                   done;
   logic [LANES*LEN_W-1:0] result;
`ifdef SC_STREAM_OUT_EN
   logic [LANES-1:0]       dbg_sa;
   logic [LANES-1:0]       dbg_sb;
   logic [LANES-1:0]       dbg_prod;
   logic                   dbg_valid;
`endif

   int checks = 0;
   int errors = 0;

   sc_mult_engine #(.WIDTH(WIDTH), .LEN_W(LEN_W), .LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .nummax    (nummax),
      .a_val     (a_val),
      .b_val     (b_val),
      .busy      (busy),
      .done      (done),
      .result    (result)
`ifdef SC_STREAM_OUT_EN
      ,
      .dbg_sa    (dbg_sa),
      .dbg_sb    (dbg_sb),
      .dbg_prod  (dbg_prod),
      .dbg_valid (dbg_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string                  name;
      logic                   mode;
      int                     n;
      logic [LANES*WIDTH-1:0] a;
      logic [LANES*WIDTH-1:0] b;
      logic [LANES*LEN_W-1:0] exp;
   } vec_t;

   task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [LANES*LEN_W-1:0] pack_res(input int r0, input int r1, input int r2, input int r3);
      return {LEN_W'(r3), LEN_W'(r2), LEN_W'(r1), LEN_W'(r0)};
   endfunction

   // Drive a launch; returns just after the accepting edge.
   task automatic launch(input logic m, input int n, input logic [LANES*WIDTH-1:0] a,
                         input logic [LANES*WIDTH-1:0] b);
      @(negedge clk);
      mode   = m;
      nummax = LEN_W'(n);
      a_val  = a;
      b_val  = b;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Count cycles from the accepting edge to done; lat = -1 on timeout.
   task automatic wait_done(input int limit, output int lat, output bit busy_seen);
      lat       = -1;
      busy_seen = busy;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (busy) busy_seen = 1'b1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_check(input string name, input logic m, input int n,
                            input logic [LANES*WIDTH-1:0] a, input logic [LANES*WIDTH-1:0] b,
                            input logic [LANES*LEN_W-1:0] exp);
      int lat;
      bit bs;
      launch(m, n, a, b);
      wait_done(n + 10, lat, bs);
      chk({name, " latency"}, longint'(lat), longint'(n + 1));
      chk({name, " busy"}, longint'(bs), longint'(n != 0));
      chk({name, " result"}, result, exp);
      @(posedge clk);
      #1;
      chk({name, " done pulse width"}, done, 0);
   endtask

   // Reference: counts derived from operand semantics over full LFSR periods or saturated operands.
   function automatic int ref_count(input logic m, input int n, input int a, input int b);
      int p;
      int pa;
      int pb;
      p  = n / PMAX;
      pa = (a == PMAX) ? n : (a == 0) ? 0 : p * a;
      pb = (b == PMAX) ? n : (b == 0) ? 0 : p * b;
      if (!m) begin
         if (a == 0 || b == 0) return 0;
         if (a == PMAX) return pb;
         return pa;
      end
      if (a == PMAX) return pb;
      if (a == 0)    return n - pb;
      if (b == PMAX) return pa;
      return n - pa;
   endfunction

   vec_t vecs[7];

   initial begin
      int lat;
      bit bs;
      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 1'b0;
      nummax = '0;
      a_val  = '0;
      b_val  = '0;

      vecs[0] = '{"uni_full_ones", 1'b0, 255, {4{8'hFF}}, {4{8'hFF}}, pack_res(255, 255, 255, 255)};
      vecs[1] = '{"uni_half",      1'b0, 255, {4{8'hFF}}, {4{8'h80}}, pack_res(128, 128, 128, 128)};
      vecs[2] = '{"uni_zero",      1'b0, 255, {4{8'h00}}, {4{8'h80}}, pack_res(0, 0, 0, 0)};
      vecs[3] = '{"bip_mix",       1'b1, 255, {8'h00, 8'hFF, 8'h00, 8'hFF},
                  {8'hFF, 8'hFF, 8'h00, 8'h00}, pack_res(0, 255, 255, 0)};
      vecs[4] = '{"n_zero",        1'b0, 0,   {4{8'hFF}}, {4{8'hFF}}, pack_res(0, 0, 0, 0)};
      vecs[5] = '{"uni_wrap",      1'b0, 510, {4{8'hFF}}, {4{8'h40}}, pack_res(128, 128, 128, 128)};
      vecs[6] = '{"bip_short",     1'b1, 7,   {4{8'h00}}, {4{8'h00}}, pack_res(7, 7, 7, 7)};

      #12;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_check(vecs[i].name, vecs[i].mode, vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Randomized runs: saturated operands at any N, or one free operand over whole periods.
      for (int it = 0; it < 16; it++) begin
         logic                   m;
         int                     n;
         bit                     full;
         logic [LANES*WIDTH-1:0] a;
         logic [LANES*WIDTH-1:0] b;
         logic [LANES*LEN_W-1:0] exp;
         m    = 1'($urandom_range(0, 1));
         full = 1'($urandom_range(0, 1));
         n    = full ? int'(PMAX) * int'($urandom_range(1, 2)) : int'($urandom_range(1, 300));
         for (int l = 0; l < LANES; l++) begin
            int av;
            int bv;
            av = $urandom_range(0, 1) ? int'(PMAX) : 0;
            bv = $urandom_range(0, 1) ? int'(PMAX) : 0;
            if (full) begin
               if ($urandom_range(0, 1)) bv = $urandom_range(0, PMAX);
               else                      av = $urandom_range(0, PMAX);
               if (av != 0 && av != int'(PMAX) && bv != 0 && bv != int'(PMAX)) bv = int'(PMAX);
            end
            a[l*WIDTH +: WIDTH]   = WIDTH'(av);
            b[l*WIDTH +: WIDTH]   = WIDTH'(bv);
            exp[l*LEN_W +: LEN_W] = LEN_W'(ref_count(m, n, av, bv));
         end
         run_check($sformatf("rand%0d", it), m, n, a, b, exp);
      end

      // start during RUN must not disturb the run in flight.
      launch(1'b0, 255, {4{8'hFF}}, {4{8'h80}});
      repeat (50) @(posedge clk);
      @(negedge clk);
      mode   = 1'b1;
      nummax = LEN_W'(3);
      a_val  = '0;
      b_val  = {4{8'hFF}};
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(300, lat, bs);
      chk("ignore_start latency", longint'(lat), 256 - 51);
      chk("ignore_start result", result, pack_res(128, 128, 128, 128));

      // Back-to-back: second launch accepted in the DONE cycle.
      launch(1'b0, 20, {4{8'hFF}}, {4{8'hFF}});
      repeat (20) @(posedge clk);
      #1;
      mode   = 1'b1;
      nummax = LEN_W'(30);
      a_val  = '0;
      b_val  = '0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      chk("b2b first done", done, 1);
      chk("b2b first result", result, pack_res(20, 20, 20, 20));
      chk("b2b second busy", busy, 1);
      wait_done(50, lat, bs);
      chk("b2b second latency", longint'(lat), 31);
      chk("b2b second result", result, pack_res(30, 30, 30, 30));

      // Reset mid-RUN aborts at once; later runs start from reloaded seeds.
      launch(1'b0, 255, {4{8'hFF}}, {4{8'hFF}});
      repeat (100) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_check("post_reset_short", 1'b0, 100, {4{8'hFF}}, {4{8'hFF}}, pack_res(100, 100, 100, 100));
      run_check("post_reset_half", 1'b0, 255, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                {8'h10, 8'hC0, 8'h01, 8'h80}, pack_res(128, 1, 192, 16));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
